// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared leaf/spine flit format, address widths and tx FSM states
// Contents:
//   GRP_W/LEAF_W/DEST_W/LEN_W/FLIT_W  address and flit field widths
//   HDR_TYPE/HDR_DEST/HDR_SRC_GRP/HDR_LEN  LSB positions of header fields
//   FLIT_HEAD                          type code carried in a header flit
//   tx_state_e                         leaf transmitter FSM states
//   make_header()                      packs a header flit from its fields
package noc_pkg;

    localparam int GRP_W  = 4;
    localparam int LEAF_W = 2;
    localparam int DEST_W = 6;
    localparam int LEN_W  = 4;
    localparam int FLIT_W = 16;

    localparam int HDR_TYPE    = 14;
    localparam int HDR_DEST    = 8;
    localparam int HDR_SRC_GRP = 4;
    localparam int HDR_LEN     = 0;

    localparam logic [1:0] FLIT_HEAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } tx_state_e;

    function automatic logic [FLIT_W-1:0] make_header(
        input logic [DEST_W-1:0] dest,
        input logic [GRP_W-1:0]  src_grp,
        input logic [LEN_W-1:0]  len
    );
        logic [FLIT_W-1:0] h;
        h = '0;
        h[HDR_TYPE    +: 2]      = FLIT_HEAD;
        h[HDR_DEST    +: DEST_W] = dest;
        h[HDR_SRC_GRP +: GRP_W]  = src_grp;
        h[HDR_LEN     +: LEN_W]  = len;
        return h;
    endfunction

endpackage

// File: rtl/leaf_uplink_tx_if.sv
// rtl/leaf_uplink_tx_if.sv - descriptor, payload, flit and credit signals of one leaf uplink
// Signals:
//   pkt_valid/pkt_ready/pkt_dest/pkt_len  packet descriptor handshake
//   pld_valid/pld_ready/pld_data          payload word handshake
//   tx_data/tx_valid                      flit stream to spine ingress (valid-only)
//   credit_return/credits                 spine credit return and current count
//   err_self/err_credit                   error pulses
// Modports: slave = transmitter, master = local leaf logic plus spine side.
interface leaf_uplink_tx_if import noc_pkg::*; #(
    parameter int DWIDTH     = 16,
    parameter int FIFO_DEPTH = 8
);

    logic                              pkt_valid;
    logic                              pkt_ready;
    logic [DEST_W-1:0]                 pkt_dest;
    logic [LEN_W-1:0]                  pkt_len;
    logic                              pld_valid;
    logic                              pld_ready;
    logic [DWIDTH-1:0]                 pld_data;
    logic [DWIDTH-1:0]                 tx_data;
    logic                              tx_valid;
    logic                              credit_return;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   credits;
    logic                              err_self;
    logic                              err_credit;

    modport slave (
        input  pkt_valid, pkt_dest, pkt_len, pld_valid, pld_data, credit_return,
        output pkt_ready, pld_ready, tx_data, tx_valid, credits, err_self, err_credit
    );

    modport master (
        output pkt_valid, pkt_dest, pkt_len, pld_valid, pld_data, credit_return,
        input  pkt_ready, pld_ready, tx_data, tx_valid, credits, err_self, err_credit
    );

endinterface

// File: rtl/link_credit_counter.sv
// rtl/link_credit_counter.sv - credit counter for one link, sized to the far-end FIFO depth
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   issue          a flit is sent this cycle (caller gates it with has_credit)
//   credit_return  far end drained one flit
//   credits        current credit count, DEPTH after reset
//   has_credit     credits > 0
//   err_credit     registered pulse: return arrived with the counter already full
module link_credit_counter #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue,
    input  logic                         credit_return,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         has_credit,
    output logic                         err_credit
);

    localparam int CW = $clog2(DEPTH+1);

    logic full;
    logic ret_ok;

    assign full       = (credits == CW'(DEPTH));
    // A return while full cannot correspond to a flit in flight, so it is dropped.
    assign ret_ok     = credit_return && !full;
    assign has_credit = (credits != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            credits    <= CW'(DEPTH);
            err_credit <= 1'b0;
        end else begin
            err_credit <= credit_return && full;
            if (issue && !ret_ok) begin
                credits <= credits - 1'b1;
            end else if (ret_ok && !issue) begin
                credits <= credits + 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_uplink_tx.sv
// rtl/leaf_uplink_tx.sv - leaf-to-spine transmitter: header + payload flits under credit flow control
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         leaf_uplink_tx_if.slave: descriptor/payload in, flits out, credits, error pulses
module leaf_uplink_tx import noc_pkg::*; #(
    parameter logic [GRP_W-1:0]  GROUP_ID   = 4'b0011,
    parameter logic [LEAF_W-1:0] LEAF_ID    = 2'd0,
    parameter int                DWIDTH     = 16,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    leaf_uplink_tx_if.slave   bus
);

    tx_state_e         state;
    tx_state_e         state_d;
    logic [DEST_W-1:0] dest_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remaining;

    logic              has_credit;
    logic              issue;
    logic [DWIDTH-1:0] flit;
    logic              pkt_acc;
    logic              pld_acc;
    logic              self_hit;

    link_credit_counter #(
        .DEPTH (FIFO_DEPTH)
    ) u_credit (
        .clk           (clk),
        .reset         (reset),
        .issue         (issue),
        .credit_return (bus.credit_return),
        .credits       (bus.credits),
        .has_credit    (has_credit),
        .err_credit    (bus.err_credit)
    );

    always_comb begin
        state_d       = state;
        issue         = 1'b0;
        flit          = '0;
        pkt_acc       = 1'b0;
        pld_acc       = 1'b0;
        self_hit      = 1'b0;
        bus.pkt_ready = 1'b0;
        bus.pld_ready = 1'b0;
        unique case (state)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted then.
                bus.pkt_ready = !reset;
                pkt_acc       = bus.pkt_valid && !reset;
                if (pkt_acc) begin
                    if (bus.pkt_dest == {GROUP_ID, LEAF_ID}) begin
                        self_hit = 1'b1;
                    end else begin
                        state_d = HEAD;
                    end
                end
            end
            HEAD: begin
                if (has_credit) begin
                    issue   = 1'b1;
                    flit    = DWIDTH'(make_header(dest_q, GROUP_ID, len_q));
                    state_d = (len_q == '0) ? IDLE : BODY;
                end
            end
            BODY: begin
                bus.pld_ready = has_credit;
                pld_acc       = bus.pld_valid && has_credit;
                if (pld_acc) begin
                    issue = 1'b1;
                    flit  = bus.pld_data;
                    if (remaining == LEN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dest_q       <= '0;
            len_q        <= '0;
            remaining    <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.err_self <= 1'b0;
        end else begin
            state        <= state_d;
            bus.tx_valid <= issue;
            bus.tx_data  <= issue ? flit : '0;
            bus.err_self <= self_hit;
            if (pkt_acc) begin
                dest_q <= bus.pkt_dest;
                len_q  <= bus.pkt_len;
            end
            if (state == HEAD && issue) begin
                remaining <= len_q;
            end else if (pld_acc) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_leaf_uplink_tx.sv
// tb/tb_leaf_uplink_tx.sv - self-checking bench for leaf_uplink_tx against a flit-stream and spine-occupancy model
module tb_leaf_uplink_tx;
    import noc_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [3:0] GRP   = 4'b0011;
    localparam logic [1:0] LEAF  = 2'd0;
    localparam logic [5:0] OWN   = {GRP, LEAF};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    leaf_uplink_tx_if #(.DWIDTH(16), .FIFO_DEPTH(DEPTH)) bus ();

    leaf_uplink_tx #(
        .GROUP_ID   (GRP),
        .LEAF_ID    (LEAF),
        .DWIDTH     (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pld_q[$];
    int          occ       = 0;
    int          pld_rate  = 100;
    int          ret_rate  = 0;
    bit          ret_req   = 1'b0;
    bit          fixed_pld = 1'b0;
    logic [15:0] pld_base  = 16'h0;
    bit          last_pkt_hs = 1'b0;
    int          tx_seen   = 0;
    bit          ok;
    int          base_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [15:0] hdr(input logic [5:0] d, input logic [3:0] l);
        return {2'b01, d, GRP, l};
    endfunction

    task automatic step();
        bit          pkt_hs;
        bit          pld_hs;
        bit          ret;
        bit          exp_cerr;
        bit          new_self;
        int          occ_drv;
        logic [15:0] w;
        new_self = 1'b0;
        bus.pld_valid = (pld_q.size() > 0) && ($urandom_range(99) < pld_rate);
        if (bus.pld_valid) bus.pld_data = pld_q[0];
        else               bus.pld_data = 16'($urandom);
        ret = ret_req || (occ > 0 && $urandom_range(99) < ret_rate);
        bus.credit_return = ret;
        pkt_hs   = !reset && bus.pkt_valid && bus.pkt_ready;
        pld_hs   = !reset && bus.pld_valid && bus.pld_ready;
        occ_drv  = occ;
        exp_cerr = ret && occ_drv == 0;
        if (pkt_hs) begin
            if (bus.pkt_dest == OWN) begin
                new_self = 1'b1;
            end else begin
                exp_q.push_back(hdr(bus.pkt_dest, bus.pkt_len));
                for (int i = 0; i < int'(bus.pkt_len); i++) begin
                    w = fixed_pld ? pld_base + 16'(i) : 16'($urandom);
                    pld_q.push_back(w);
                    exp_q.push_back(w);
                end
            end
        end
        if (pld_hs) void'(pld_q.pop_front());
        last_pkt_hs = pkt_hs;
        @(posedge clk);
        #1;
        ret_req = 1'b0;
        if (reset) begin
            exp_q.delete();
            pld_q.delete();
            occ = 0;
            chk("rst_tx_valid", bus.tx_valid, 0);
            chk("rst_tx_data", bus.tx_data, 0);
            chk("rst_credits", bus.credits, DEPTH);
            chk("rst_err", {bus.err_self, bus.err_credit}, 0);
            chk("rst_pkt_ready", bus.pkt_ready, 0);
            chk("rst_pld_ready", bus.pld_ready, 0);
        end else begin
            if (ret && occ > 0) occ--;
            if (bus.tx_valid) begin
                tx_seen++;
                occ++;
                if (exp_q.size() == 0) chk("tx_extra", bus.tx_valid, 0);
                else                   chk("tx_data", bus.tx_data, exp_q.pop_front());
            end
            chk("credits", bus.credits, DEPTH - occ);
            chk("err_self", bus.err_self, new_self);
            chk("err_credit", bus.err_credit, exp_cerr);
            chk("pkt_ready", bus.pkt_ready, exp_q.size() == 0);
            if (pld_q.size() == 0 || occ == DEPTH) chk("pld_ready_gate", bus.pld_ready, 0);
        end
    endtask

    task automatic send(input logic [5:0] d, input logic [3:0] l, output bit acc);
        bus.pkt_valid = 1'b1;
        bus.pkt_dest  = d;
        bus.pkt_len   = l;
        acc = 1'b0;
        for (int i = 0; i < 300 && !acc; i++) begin
            step();
            acc = last_pkt_hs;
        end
        bus.pkt_valid = 1'b0;
        bus.pkt_dest  = 6'($urandom);
        bus.pkt_len   = 4'($urandom);
        chk("accept_in_time", acc, 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (exp_q.size() > 0 && n < max) begin
            step();
            n++;
        end
        chk("idle_in_time", exp_q.size(), 0);
    endtask

    task automatic drain(input int max);
        int n = 0;
        int keep = ret_rate;
        ret_rate = 100;
        while (occ > 0 && n < max) begin
            step();
            n++;
        end
        ret_rate = keep;
        chk("drain_in_time", occ, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.pkt_valid     = 1'b0;
        bus.pkt_dest      = '0;
        bus.pkt_len       = '0;
        bus.pld_valid     = 1'b0;
        bus.pld_data      = '0;
        bus.credit_return = 1'b0;

        // reset and release
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rel_pkt_ready", bus.pkt_ready, 1);
        chk("rel_pld_ready", bus.pld_ready, 0);
        chk("rel_credits", bus.credits, DEPTH);

        // three-word packet: latency, throughput, credits
        fixed_pld = 1'b1;
        pld_base  = 16'hA001;
        pld_rate  = 100;
        ret_rate  = 0;
        send(6'b0100_01, 4'd3, ok);
        chk("p1_quiet_t1", bus.tx_valid, 0);
        step();
        chk("p1_hdr_valid", bus.tx_valid, 1);
        chk("p1_hdr_data", bus.tx_data, 16'h5133);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("p1_pld_valid", bus.tx_valid, 1);
            chk("p1_pld_data", bus.tx_data, 16'hA001 + 16'(i));
        end
        chk("p1_credits", bus.credits, 4);
        chk("p1_bubble", bus.pkt_ready, 1);
        fixed_pld = 1'b0;
        drain(50);

        // header-only packet
        send(6'b0001_10, 4'd0, ok);
        chk("p2_busy", bus.pkt_ready, 0);
        step();
        chk("p2_hdr_data", bus.tx_data, 16'h4630);
        chk("p2_ready_again", bus.pkt_ready, 1);
        drain(50);

        // own-leaf destination is dropped
        send(OWN, 4'd5, ok);
        chk("p3_err_self", bus.err_self, 1);
        chk("p3_no_tx", bus.tx_valid, 0);
        step();
        step();
        chk("p3_credits", bus.credits, DEPTH);

        // credit exhaustion stall and per-credit resume
        ret_rate = 0;
        base_cnt = tx_seen;
        send(6'b1010_11, 4'd12, ok);
        for (int i = 0; i < 20; i++) step();
        chk("p4_flits", tx_seen - base_cnt, 8);
        chk("p4_stall_ready", bus.pld_ready, 0);
        chk("p4_stall_credits", bus.credits, 0);
        for (int i = 0; i < 3; i++) begin
            ret_req = 1'b1;
            step();
            chk("p4_ret_ready", bus.pld_ready, 1);
            step();
            chk("p4_ret_issue", bus.tx_valid, 1);
        end
        ret_rate = 100;
        wait_idle(100);
        drain(50);

        // issue and return in the same cycle
        ret_rate = 0;
        send(6'b0111_01, 4'd6, ok);
        for (int i = 0; i < 20; i++) begin
            if (occ == 3 && bus.pld_ready) break;
            step();
        end
        chk("p5_reach", occ, 3);
        ret_req = 1'b1;
        step();
        chk("p5_same_cycle", bus.credits, 5);
        wait_idle(100);
        drain(50);

        // spurious return while full
        ret_req = 1'b1;
        step();
        chk("p6_err_credit", bus.err_credit, 1);
        chk("p6_credits", bus.credits, DEPTH);
        step();
        chk("p6_pulse_end", bus.err_credit, 0);

        // reset in the middle of a body
        ret_rate = 0;
        send(6'b1100_10, 4'd8, ok);
        for (int i = 0; i < 20; i++) begin
            if (occ == 5) break;
            step();
        end
        chk("p7_reach", occ, 5);
        reset = 1'b1;
        step();
        chk("p7_tx_valid", bus.tx_valid, 0);
        chk("p7_credits", bus.credits, DEPTH);
        reset = 1'b0;
        #1;
        chk("p7_pkt_ready", bus.pkt_ready, 1);
        ret_rate = 50;
        send(6'b0010_01, 4'd4, ok);
        wait_idle(100);
        drain(50);

        // randomized traffic
        for (int p = 0; p < 40; p++) begin
            logic [5:0] d;
            logic [3:0] l;
            pld_rate = $urandom_range(40, 100);
            ret_rate = $urandom_range(20, 90);
            for (int k = 0; k < int'($urandom_range(3)); k++) step();
            d = ($urandom_range(7) == 0) ? OWN : 6'($urandom);
            l = 4'($urandom_range(15));
            send(d, l, ok);
        end
        ret_rate = 100;
        wait_idle(400);
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
